sig_control_timed: RTL and testbench
====================================

Name: sig_control_timed

Overview:
- Parametrised successor of the highway/country Moore traffic controller.
- Replaces the behavioural repeat/@-delays with a synthesisable phase down-counter.
- Adds highway minimum-green, country maximum-green timeout, and a second all-red phase on return to highway.
- Sits between the sensor/sync logic (X) and the lamp drivers (hwy, cntry).

Parameters:
- Y2R_CYCLES, 3, clocks spent in each yellow phase (S1, S4).
- R2G_CYCLES, 2, clocks spent in each all-red phase (S2, S5).
- HWY_MIN_GREEN, 8, minimum clocks in highway green (S0) before X is honoured.
- CNTRY_MAX_GREEN, 16, maximum clocks in country green (S3).
- CNT_W, 5, timer width. Must satisfy 2^CNT_W > max(all cycle params). Every cycle param must be >= 1.

Ports:
- clock  input  1  rising-edge clock
- clear  input  1  synchronous active-high reset
- X  input  1  country-road car present (already synchronised)
- emerg  input  1  emergency preempt request; ignored unless PREEMPT_EN is defined
- hwy  output  2  highway lamp (RED=0, YELLOW=1, GREEN=2)
- cntry  output  2  country lamp, same encoding
- cntry_timeout  output  1  one-cycle pulse when country green was ended by the max-green limit

Behaviour:
- Single clock `clock`. Reset `clear` is synchronous and active-high. All state changes occur on posedge clock only.
- Reset values: state=S0, timer=HWY_MIN_GREEN-1, cntry_timeout=0. Consequently hwy=GREEN, cntry=RED.
- Reset wins over every other condition, including mid-phase. The next cycle is S0 with a freshly loaded timer.
- States and lamp decode (Moore, combinational from state; lamps change in the same cycle as state):
  - S0: hwy GREEN, cntry RED
  - S1: hwy YELLOW, cntry RED
  - S2: both RED
  - S3: hwy RED, cntry GREEN
  - S4: hwy RED, cntry YELLOW
  - S5: both RED
  - Unused encodings: treated as S0 on the next edge.
- Timer rules:
  - On entry to a state, timer loads duration-1.
  - Each cycle it decrements. It saturates at 0 and never wraps.
  - `done` = (timer==0).
- Transitions, evaluated at each edge:
  - S0->S1 when done && X. With X=0, S0 holds indefinitely with timer at 0.
  - S1->S2 when done.
  - S2->S3 when done.
  - S3->S4 when !X, or when done. Exit on !X happens the cycle after X is sampled low, regardless of timer.
  - S4->S5 when done.
  - S5->S0 when done; HWY_MIN_GREEN is reloaded.
- Phase lengths: S1 and S4 last exactly Y2R_CYCLES; S2 and S5 last exactly R2G_CYCLES; S3 lasts at most CNTRY_MAX_GREEN.
- Latency: X sampled high at the edge where S0 timer==0 gives hwy=YELLOW immediately after that edge.
- cntry_timeout:
  - Registered. It is 1 during the first cycle of S4 only when the S3 exit was caused by done with X still 1.
  - If X falls on the same edge the timer expires, the exit counts as a normal exit and cntry_timeout stays 0.
- Fairness: after a timeout, S0 still enforces HWY_MIN_GREEN even if X stays high.

Optional Feature:
- Macro: SIG_CONTROL_PREEMPT_EN.
- Defined, with emerg=1:
  - S0 ignores X and holds.
  - S1 completes normally.
  - S2 exits to S5 on done instead of S3.
  - S3 exits to S4 on the next edge.
  - S4 and S5 run normally.
  - cntry_timeout is never asserted on a preempted exit.
- Undefined: emerg is unused and behaviour is exactly as above. The port remains for pin compatibility.

Decomposition:
- Package sig_control_pkg holds:
  - the lamp colour constants RED/YELLOW/GREEN (2-bit)
  - the state encodings S0..S5 (3-bit)
- Sub-module phase_timer(CNT_W):
  - synchronous load of a value
  - saturating decrement
  - `done` output
  - reset via clear

Test Plan:
- Reset hold: clear=1 for 2 cycles, X=0 for 30 cycles -> hwy=GREEN, cntry=RED throughout, cntry_timeout=0.
- Min-green: X=1 from the first cycle after clear drops -> 8 cycles GREEN/RED, 3 cycles YELLOW/RED, 2 cycles RED/RED, then RED/GREEN.
- Early release: in S3, drop X after 5 cycles -> next edge cntry=YELLOW for 3 cycles, RED/RED for 2 cycles, then hwy=GREEN; cntry_timeout stays 0.
- Timeout: hold X=1 -> cntry GREEN exactly 16 cycles, cntry_timeout=1 for 1 cycle at the first S4 cycle; after return, hwy GREEN at least 8 cycles before YELLOW again.
- Mid-phase reset: assert clear for 1 cycle during S3 cycle 4 -> next cycle hwy=GREEN, cntry=RED; X=1 then takes 8 more cycles before YELLOW.
- Preempt (SIG_CONTROL_PREEMPT_EN defined): emerg=1 during S3 -> next edge S4; emerg=1 during S2 -> S5 follows, with cntry never GREEN.

Source files
------------

// File: rtl/sig_control_pkg.sv
// -----------------------------------------------------------------------------
// sig_control_pkg
// Shared definitions for the highway/country traffic controller:
//   - 2-bit lamp colour codes (RED, YELLOW, GREEN)
//   - 3-bit controller state encodings S0..S5
//   - lamp_decode(): Moore lamp pair {hwy, cntry} for a given state
// -----------------------------------------------------------------------------
package sig_control_pkg;

    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;

    typedef enum logic [2:0] {
        S0 = 3'd0,  // highway green
        S1 = 3'd1,  // highway yellow
        S2 = 3'd2,  // all red, heading to country
        S3 = 3'd3,  // country green
        S4 = 3'd4,  // country yellow
        S5 = 3'd5   // all red, heading back to highway
    } state_e;

    // Returns {hwy, cntry}; any encoding outside S0..S5 shows all red.
    function automatic logic [3:0] lamp_decode(input state_e s);
        logic [3:0] lamps;
        case (s)
            S0:      lamps = {GREEN,  RED};
            S1:      lamps = {YELLOW, RED};
            S2:      lamps = {RED,    RED};
            S3:      lamps = {RED,    GREEN};
            S4:      lamps = {RED,    YELLOW};
            S5:      lamps = {RED,    RED};
            default: lamps = {RED,    RED};
        endcase
        return lamps;
    endfunction

endpackage

// File: rtl/sig_control_timed_phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
// Loadable saturating down-counter used to time each controller phase.
//   clock      : rising-edge clock
//   clear      : synchronous active-high reset, counter takes RST_VAL
//   load_i     : load load_val_i this edge (wins over decrement)
//   load_val_i : value to load (phase duration - 1)
//   done_o     : counter is at zero
// The counter stops at zero and never wraps.
// -----------------------------------------------------------------------------
module phase_timer #(
    parameter int unsigned      CNT_W   = 5,
    parameter logic [CNT_W-1:0] RST_VAL = {CNT_W{1'b0}}
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: load, else saturating decrement.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != {CNT_W{1'b0}}) begin
            count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Counter register with synchronous clear.
    always_ff @(posedge clock) begin
        if (clear) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/sig_control_timed.sv
// -----------------------------------------------------------------------------
// sig_control_timed
// Timed Moore traffic controller for a highway / country-road crossing.
//   clock         : rising-edge clock
//   clear         : synchronous active-high reset (state S0, timer loaded)
//   X             : country-road car present (already synchronised)
//   emerg         : emergency preempt, only honoured with SIG_CONTROL_PREEMPT_EN
//   hwy, cntry    : lamp codes (RED=0, YELLOW=1, GREEN=2), decoded from state
//   cntry_timeout : one-cycle pulse in the first S4 cycle when country green
//                   was ended by the max-green limit while X was still high
// Optional feature macro: SIG_CONTROL_PREEMPT_EN
//   When defined, emerg=1 holds S0, diverts S2 to S5 and cuts S3 short.
// Parameter constraints: every *_CYCLES / *_GREEN value >= 1 and
// 2**CNT_W greater than all of them.
// -----------------------------------------------------------------------------
module sig_control_timed
    import sig_control_pkg::*;
#(
    parameter int unsigned Y2R_CYCLES      = 3,
    parameter int unsigned R2G_CYCLES      = 2,
    parameter int unsigned HWY_MIN_GREEN   = 8,
    parameter int unsigned CNTRY_MAX_GREEN = 16,
    parameter int unsigned CNT_W           = 5
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       X,
    input  logic       emerg,
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic       cntry_timeout
);

    localparam logic [CNT_W-1:0] HWY_LOAD   = CNT_W'(HWY_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] Y2R_LOAD   = CNT_W'(Y2R_CYCLES - 1);
    localparam logic [CNT_W-1:0] R2G_LOAD   = CNT_W'(R2G_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNTRY_LOAD = CNT_W'(CNTRY_MAX_GREEN - 1);

    state_e           state_q;
    state_e           state_d;
    logic             timeout_q;
    logic             timeout_d;
    logic             load_s;
    logic [CNT_W-1:0] load_val_s;
    logic             done_s;
    logic             emerg_s;

`ifdef SIG_CONTROL_PREEMPT_EN
    assign emerg_s = emerg;
`else
    // Pin kept for compatibility; preempt is disabled in this build.
    logic emerg_unused_s;
    assign emerg_unused_s = emerg;
    assign emerg_s        = 1'b0;
`endif

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (HWY_LOAD)
    ) u_phase_timer (
        .clock      (clock),
        .clear      (clear),
        .load_i     (load_s),
        .load_val_i (load_val_s),
        .done_o     (done_s)
    );

    // Next-state and timeout-pulse logic.
    always_comb begin
        state_d   = state_q;
        timeout_d = 1'b0;
        case (state_q)
            S0: begin
                // Min-green: X is only honoured once the timer has run out.
                if (done_s && X && !emerg_s) begin
                    state_d = S1;
                end else begin
                    state_d = S0;
                end
            end
            S1: begin
                if (done_s) begin
                    state_d = S2;
                end else begin
                    state_d = S1;
                end
            end
            S2: begin
                // A preempt skips country green entirely.
                if (done_s && emerg_s) begin
                    state_d = S5;
                end else if (done_s) begin
                    state_d = S3;
                end else begin
                    state_d = S2;
                end
            end
            S3: begin
                if (!X || done_s || emerg_s) begin
                    state_d = S4;
                    // Only a pure max-green expiry with traffic still waiting
                    // counts as a timeout.
                    timeout_d = done_s && X && !emerg_s;
                end else begin
                    state_d = S3;
                end
            end
            S4: begin
                if (done_s) begin
                    state_d = S5;
                end else begin
                    state_d = S4;
                end
            end
            S5: begin
                if (done_s) begin
                    state_d = S0;
                end else begin
                    state_d = S5;
                end
            end
            default: begin
                state_d = S0;
            end
        endcase
    end

    // Timer reload on every state change, with the new state's duration.
    always_comb begin
        load_s = (state_d != state_q);
        case (state_d)
            S0:      load_val_s = HWY_LOAD;
            S1:      load_val_s = Y2R_LOAD;
            S2:      load_val_s = R2G_LOAD;
            S3:      load_val_s = CNTRY_LOAD;
            S4:      load_val_s = Y2R_LOAD;
            S5:      load_val_s = R2G_LOAD;
            default: load_val_s = HWY_LOAD;
        endcase
    end

    // State and timeout-pulse registers with synchronous clear.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= S0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timeout_q <= timeout_d;
        end
    end

    // Moore lamp decode from the current state.
    always_comb begin
        {hwy, cntry} = lamp_decode(state_q);
    end

    assign cntry_timeout = timeout_q;

endmodule

// File: tb/tb_sig_control_timed.sv
// -----------------------------------------------------------------------------
// tb_sig_control_timed
// Directed self-checking bench for sig_control_timed with default parameters.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_sig_control_timed;

    localparam logic [1:0] L_R = 2'd0;
    localparam logic [1:0] L_Y = 2'd1;
    localparam logic [1:0] L_G = 2'd2;

    logic       clock;
    logic       clear;
    logic       X;
    logic       emerg;
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic       cntry_timeout;

    int n_checks;
    int n_pass;

    sig_control_timed dut (
        .clock         (clock),
        .clear         (clear),
        .X             (X),
        .emerg         (emerg),
        .hwy           (hwy),
        .cntry         (cntry),
        .cntry_timeout (cntry_timeout)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Check {hwy, cntry, cntry_timeout} for n consecutive cycles.
    task automatic expect_cycles(input int n, input logic [1:0] h, input logic [1:0] c,
                                 input logic t, input string tag);
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s[%0d]", tag, i),
                     {27'd0, hwy, cntry, cntry_timeout},
                     {27'd0, h, c, t});
            tick();
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        clear    = 1'b1;
        X        = 1'b0;
        emerg    = 1'b0;
        tick();
        tick();

        // Reset hold: no traffic, highway stays green.
        clear = 1'b0;
        expect_cycles(30, L_G, L_R, 1'b0, "reset_hold");

        // Min-green then handover to country.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        X     = 1'b1;
        expect_cycles(8, L_G, L_R, 1'b0, "mg_green");
        expect_cycles(3, L_Y, L_R, 1'b0, "mg_yellow");
        expect_cycles(2, L_R, L_R, 1'b0, "mg_allred");

        // Early release after 5 cycles of country green.
        expect_cycles(5, L_R, L_G, 1'b0, "er_cgreen");
        X = 1'b0;
        expect_cycles(1, L_R, L_G, 1'b0, "er_lastg");
        expect_cycles(3, L_R, L_Y, 1'b0, "er_cyellow");
        expect_cycles(2, L_R, L_R, 1'b0, "er_allred");

        // Timeout: country green capped at 16 with X held.
        X = 1'b1;
        expect_cycles(8, L_G, L_R, 1'b0, "to_hgreen");
        expect_cycles(3, L_Y, L_R, 1'b0, "to_hyellow");
        expect_cycles(2, L_R, L_R, 1'b0, "to_allred");
        expect_cycles(16, L_R, L_G, 1'b0, "to_cgreen");
        expect_cycles(1, L_R, L_Y, 1'b1, "to_pulse");
        expect_cycles(2, L_R, L_Y, 1'b0, "to_cyellow");
        expect_cycles(2, L_R, L_R, 1'b0, "to_allred2");
        // Fairness: min-green enforced although X stays high.
        expect_cycles(8, L_G, L_R, 1'b0, "fair_green");
        expect_cycles(1, L_Y, L_R, 1'b0, "fair_yellow");

        // Mid-phase reset in S3 cycle 4.
        expect_cycles(2, L_Y, L_R, 1'b0, "mr_yellow");
        expect_cycles(2, L_R, L_R, 1'b0, "mr_allred");
        expect_cycles(3, L_R, L_G, 1'b0, "mr_cgreen");
        clear = 1'b1;
        expect_cycles(1, L_R, L_G, 1'b0, "mr_cyc4");
        clear = 1'b0;
        expect_cycles(8, L_G, L_R, 1'b0, "mr_hgreen");
        expect_cycles(1, L_Y, L_R, 1'b0, "mr_yellow2");

        // X falls on the same edge the max-green timer expires: no pulse.
        expect_cycles(2, L_Y, L_R, 1'b0, "se_yellow");
        expect_cycles(2, L_R, L_R, 1'b0, "se_allred");
        expect_cycles(15, L_R, L_G, 1'b0, "se_cgreen");
        X = 1'b0;
        expect_cycles(1, L_R, L_G, 1'b0, "se_lastg");
        expect_cycles(1, L_R, L_Y, 1'b0, "se_nopulse");
        expect_cycles(2, L_R, L_Y, 1'b0, "se_cyellow");
        expect_cycles(2, L_R, L_R, 1'b0, "se_allred2");

`ifdef SIG_CONTROL_PREEMPT_EN
        // S0 holds under emerg even with X high and timer expired.
        X     = 1'b1;
        emerg = 1'b1;
        expect_cycles(10, L_G, L_R, 1'b0, "pe_hold");
        emerg = 1'b0;
        expect_cycles(1, L_G, L_R, 1'b0, "pe_release");
        expect_cycles(3, L_Y, L_R, 1'b0, "pe_yellow");
        expect_cycles(2, L_R, L_R, 1'b0, "pe_allred");
        // emerg in S3: next edge S4, no timeout pulse.
        emerg = 1'b1;
        expect_cycles(1, L_R, L_G, 1'b0, "pe_s3");
        expect_cycles(1, L_R, L_Y, 1'b0, "pe_s4");
        emerg = 1'b0;
        expect_cycles(2, L_R, L_Y, 1'b0, "pe_s4b");
        expect_cycles(2, L_R, L_R, 1'b0, "pe_s5");
        expect_cycles(8, L_G, L_R, 1'b0, "pe_hgreen");
        expect_cycles(3, L_Y, L_R, 1'b0, "pe_yellow2");
        // emerg in S2: diverted to S5, country never green.
        emerg = 1'b1;
        expect_cycles(2, L_R, L_R, 1'b0, "pe_s2");
        expect_cycles(2, L_R, L_R, 1'b0, "pe_s5b");
        expect_cycles(1, L_G, L_R, 1'b0, "pe_back");
`else
        // emerg is ignored: full normal cycle including timeout pulse.
        X     = 1'b1;
        emerg = 1'b1;
        expect_cycles(8, L_G, L_R, 1'b0, "ig_hgreen");
        expect_cycles(3, L_Y, L_R, 1'b0, "ig_yellow");
        expect_cycles(2, L_R, L_R, 1'b0, "ig_allred");
        expect_cycles(16, L_R, L_G, 1'b0, "ig_cgreen");
        expect_cycles(1, L_R, L_Y, 1'b1, "ig_pulse");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
